avr_cpu_hw_stack: RTL and testbench
===================================

# avr_cpu_hw_stack

Parametrised hardware return-address stack for the AVR CPU core, replacing the fixed 3-entry bidirectional-port stack. It stores pushed program-counter words for CALL/RCALL/ICALL/interrupt entry and returns them on RET/RETI. It adds:
- separate input and output ports, with the top-of-stack visible before the pop
- simultaneous push+pop (replace)
- occupancy, full and empty status
- overflow and underflow reporting
- optional circular overwrite of the oldest entry

## Interface
Parameters:
- DATA_WIDTH, 22: width of one stack entry (PC width).
- STACK_DEPTH, 8: number of entries; any integer ≥ 2, power of two not required.
- ADDR_WIDTH, $clog2(STACK_DEPTH+1): width of `level`.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- push  in  1  push `din` this cycle.
- pop  in  1  remove top entry this cycle.
- din  in  DATA_WIDTH  value to push.
- dout  out  DATA_WIDTH  current top entry; 0 when empty.
- level  out  ADDR_WIDTH  number of valid entries, 0..STACK_DEPTH.
- empty  out  1  level == 0.
- full  out  1  level == STACK_DEPTH.
- ovf  out  1  one-cycle pulse: push accepted or attempted while full.
- unf  out  1  one-cycle pulse: pop while empty.

## Operation
- Storage is a STACK_DEPTH-entry circular array with a top pointer `tp` (index of top entry) and the counter `level`.
- `dout` is a combinational read of `mem[tp]`, gated to 0 when empty. It depends only on registered state; there is no din/push/pop→dout path.
- Per rising edge, when not in reset:
  - push only, not full: `tp` ← `tp`+1 mod STACK_DEPTH; `mem[new tp]` ← din; `level` +1.
  - push only, full: handled per Configuration; `ovf`=1 next cycle.
  - pop only, not empty: `tp` ← `tp`−1 mod STACK_DEPTH; `level` −1.
  - pop only, empty: no state change; `unf`=1 next cycle.
  - push+pop, not empty: replace, `mem[tp]` ← din; `tp` and `level` unchanged; no flag.
  - push+pop, empty: treated as push only (level becomes 1); `unf`=1.
  - neither: hold.
- `ovf` and `unf` are registered and high for exactly the cycle after the offending edge. They are never both high.
- Pointer arithmetic wraps modulo STACK_DEPTH explicitly, so it is correct for non-power-of-two depths.
- `level` never exceeds STACK_DEPTH and never goes below 0.

## Timing
- Reset: `level`=0, `tp`=0, `empty`=1, `full`=0, `ovf`=0, `unf`=0, `dout`=0. Memory contents are not reset.
- Push latency 1: din pushed at edge N appears on `dout` after edge N.
- Pop read latency 0: the consumer samples `dout` in the same cycle it asserts `pop`. After the edge, `dout` shows the next entry.
- Back-to-back push/pop every cycle is supported with no bubbles.
- `rst` has priority over push/pop. Reset during any operation discards all entries, and flags clear on the same edge.
- `empty` and `full` are decoded from registered `level` and are valid in the same cycle as it.

## Configuration
- Macro `AVR_CPU_STACK_WRAP_EN`.
- Defined: a push while full overwrites the oldest entry. `tp` advances, `mem[new tp]` ← din, `level` stays STACK_DEPTH, and `ovf` pulses. The newest STACK_DEPTH return addresses are retained, so deep recursion loses the oldest frames.
- Not defined: a push while full is dropped. Memory, `tp` and `level` are unchanged, `ovf` pulses, and `dout` still shows the previous top.

## Test plan
- Reset, then idle 3 cycles → `level`=0, `empty`=1, `dout`=0, `ovf`=`unf`=0.
- DEPTH=8: push 0x000001..0x000008, then pop 8 times, sampling `dout` before each pop → `dout` reads 8,7,…,1. `full`=1 after the 8th push. `empty`=1 after the last pop. No flags raised.
- Push 0xA, push 0xB, then push+pop with din=0xC → `level`=2, `dout`=0xC. Pop → `dout`=0xA.
- Full stack (1..8), push 0x9 → `ovf` pulses one cycle.
  - Without the macro: `dout`=8, and popping 8 times yields 8..1.
  - With `AVR_CPU_STACK_WRAP_EN`: `dout`=9, and popping 8 times yields 9..2.
- Pop on an empty stack → `unf`=1 for one cycle, `level`=0. Push+pop on empty with din=0x5 → `level`=1, `dout`=0x5, `unf`=1.
- Push 3 entries, assert `rst` together with push → next cycle `level`=0, `dout`=0, no flags. DEPTH=5 instance: 12 alternating push/pop patterns across wrap → LIFO order preserved.

Source files
------------

// File: rtl/avr_cpu_hw_stack.sv
// Parametrised return-address stack for the AVR CPU: circular LIFO with level/full/empty and ovf/unf pulses.
// Optional macro AVR_CPU_STACK_WRAP_EN: a push while full overwrites the oldest entry instead of being dropped.
module avr_cpu_hw_stack #(
  parameter int unsigned DATA_WIDTH  = 22,
  parameter int unsigned STACK_DEPTH = 8,
  parameter int unsigned ADDR_WIDTH  = $clog2(STACK_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [ADDR_WIDTH-1:0] level,
  output logic                  empty,
  output logic                  full,
  output logic                  ovf,
  output logic                  unf
);

  localparam int unsigned PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [PTR_W-1:0]      PTR_LAST = PTR_W'(STACK_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] LVL_FULL = ADDR_WIDTH'(STACK_DEPTH);

  logic [DATA_WIDTH-1:0] mem [STACK_DEPTH];

  logic [PTR_W-1:0]      tp_q, tp_d;
  logic [ADDR_WIDTH-1:0] level_q, level_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  we_c;
  logic [PTR_W-1:0]      wa_c;
  logic [PTR_W-1:0]      tp_inc_c, tp_dec_c;
  logic                  empty_c, full_c;

  assign empty_c = (level_q == '0);
  assign full_c  = (level_q == LVL_FULL);

  // Explicit modulo wrap so non-power-of-two depths index correctly
  assign tp_inc_c = (tp_q == PTR_LAST) ? '0 : tp_q + PTR_W'(1);
  assign tp_dec_c = (tp_q == '0) ? PTR_LAST : tp_q - PTR_W'(1);

  always_comb begin
    tp_d    = tp_q;
    level_d = level_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    we_c    = 1'b0;
    wa_c    = tp_q;
    if (!rst) begin
      if (push && pop) begin
        if (empty_c) begin
          // Nothing to pop: behaves as a plain push, but the pop is flagged
          tp_d    = tp_inc_c;
          level_d = ADDR_WIDTH'(1);
          we_c    = 1'b1;
          wa_c    = tp_inc_c;
          unf_d   = 1'b1;
        end else begin
          we_c = 1'b1;
          wa_c = tp_q;
        end
      end else if (push) begin
        if (!full_c) begin
          tp_d    = tp_inc_c;
          level_d = level_q + ADDR_WIDTH'(1);
          we_c    = 1'b1;
          wa_c    = tp_inc_c;
        end else begin
`ifdef AVR_CPU_STACK_WRAP_EN
          tp_d  = tp_inc_c;
          we_c  = 1'b1;
          wa_c  = tp_inc_c;
`endif
          ovf_d = 1'b1;
        end
      end else if (pop) begin
        if (!empty_c) begin
          tp_d    = tp_dec_c;
          level_d = level_q - ADDR_WIDTH'(1);
        end else begin
          unf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tp_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      tp_q    <= tp_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (we_c) mem[wa_c] <= din;
  end

  assign dout  = empty_c ? '0 : mem[tp_q];
  assign level = level_q;
  assign empty = empty_c;
  assign full  = full_c;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: tb/tb_avr_cpu_hw_stack.sv
// Self-checking bench: depth-8 and depth-5 stacks against a queue-based LIFO model, directed plus random traffic.
module tb_avr_cpu_hw_stack;

  localparam int unsigned DW = 22;

  logic          clk = 1'b0;
  logic          rst;
  logic          push8, pop8, push5, pop5;
  logic [DW-1:0] din8, din5;
  logic [DW-1:0] dout8, dout5;
  logic [3:0]    level8;
  logic [2:0]    level5;
  logic          empty8, full8, ovf8, unf8;
  logic          empty5, full5, ovf5, unf5;

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  logic [DW-1:0] q8[$];
  logic [DW-1:0] q5[$];
  logic eo8 = 1'b0, eu8 = 1'b0, eo5 = 1'b0, eu5 = 1'b0;

  always #5 clk = ~clk;

  avr_cpu_hw_stack #(.DATA_WIDTH(DW), .STACK_DEPTH(8)) u_d8 (
    .clk(clk), .rst(rst), .push(push8), .pop(pop8), .din(din8),
    .dout(dout8), .level(level8), .empty(empty8), .full(full8), .ovf(ovf8), .unf(unf8)
  );

  avr_cpu_hw_stack #(.DATA_WIDTH(DW), .STACK_DEPTH(5)) u_d5 (
    .clk(clk), .rst(rst), .push(push5), .pop(pop5), .din(din5),
    .dout(dout5), .level(level5), .empty(empty5), .full(full5), .ovf(ovf5), .unf(unf5)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stack semantics as a queue: back of the queue is the top of stack
  task automatic model_step(input int idx, input logic r, input logic pu, input logic po,
                            input logic [DW-1:0] d);
    logic [DW-1:0] q[$];
    int depth;
    logic o, u;
    o = 1'b0;
    u = 1'b0;
    if (idx == 0) begin q = q8; depth = 8; end
    else begin q = q5; depth = 5; end
    if (r) begin
      q.delete();
    end else if (pu && po) begin
      if (q.size() == 0) begin q.push_back(d); u = 1'b1; end
      else q[q.size()-1] = d;
    end else if (pu) begin
      if (q.size() < depth) q.push_back(d);
      else begin
        o = 1'b1;
`ifdef AVR_CPU_STACK_WRAP_EN
        void'(q.pop_front());
        q.push_back(d);
`endif
      end
    end else if (po) begin
      if (q.size() > 0) void'(q.pop_back());
      else u = 1'b1;
    end
    if (idx == 0) begin q8 = q; eo8 = o; eu8 = u; end
    else begin q5 = q; eo5 = o; eu5 = u; end
  endtask

  function automatic logic [DW-1:0] top_of(input int idx);
    if (idx == 0) return (q8.size() == 0) ? '0 : q8[q8.size()-1];
    return (q5.size() == 0) ? '0 : q5[q5.size()-1];
  endfunction

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("d8_dout",  32'(dout8),  32'(top_of(0)));
      check("d8_level", 32'(level8), 32'(q8.size()));
      check("d8_empty", 32'(empty8), 32'(q8.size() == 0));
      check("d8_full",  32'(full8),  32'(q8.size() == 8));
      check("d8_ovf",   32'(ovf8),   32'(eo8));
      check("d8_unf",   32'(unf8),   32'(eu8));
      check("d5_dout",  32'(dout5),  32'(top_of(1)));
      check("d5_level", 32'(level5), 32'(q5.size()));
      check("d5_empty", 32'(empty5), 32'(q5.size() == 0));
      check("d5_full",  32'(full5),  32'(q5.size() == 5));
      check("d5_ovf",   32'(ovf5),   32'(eo5));
      check("d5_unf",   32'(unf5),   32'(eu5));
    end
  end

  task automatic cyc(input logic r, input logic pu8, input logic po8, input logic [DW-1:0] d8,
                     input logic pu5, input logic po5, input logic [DW-1:0] d5);
    rst = r; push8 = pu8; pop8 = po8; din8 = d8; push5 = pu5; pop5 = po5; din5 = d5;
    @(posedge clk);
    model_step(0, r, pu8, po8, d8);
    model_step(1, r, pu5, po5, d5);
    #1;
  endtask

  task automatic c8(input logic r, input logic pu, input logic po, input logic [DW-1:0] d);
    cyc(r, pu, po, d, 1'b0, 1'b0, '0);
  endtask

  initial begin
    rst = 1'b1; push8 = 1'b0; pop8 = 1'b0; din8 = '0; push5 = 1'b0; pop5 = 1'b0; din5 = '0;
    c8(1'b1, 1'b0, 1'b0, '0);
    chk_en = 1'b1;
    c8(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) c8(1'b0, 1'b0, 1'b0, '0);
    check("rst_level", 32'(level8), 32'd0);
    check("rst_empty", 32'(empty8), 32'd1);
    check("rst_dout",  32'(dout8),  32'd0);
    check("rst_flags", 32'({ovf8, unf8}), 32'd0);

    // Fill then drain: LIFO order, sampling dout before each pop
    for (int i = 1; i <= 8; i++) c8(1'b0, 1'b1, 1'b0, DW'(i));
    check("fill_full", 32'(full8), 32'd1);
    for (int i = 8; i >= 1; i--) begin
      check("drain_dout", 32'(dout8), 32'(i));
      c8(1'b0, 1'b0, 1'b1, '0);
    end
    check("drain_empty", 32'(empty8), 32'd1);

    // Replace
    c8(1'b0, 1'b1, 1'b0, DW'('hA));
    c8(1'b0, 1'b1, 1'b0, DW'('hB));
    c8(1'b0, 1'b1, 1'b1, DW'('hC));
    check("repl_level", 32'(level8), 32'd2);
    check("repl_dout",  32'(dout8),  32'hC);
    c8(1'b0, 1'b0, 1'b1, '0);
    check("repl_pop_dout", 32'(dout8), 32'hA);
    c8(1'b0, 1'b0, 1'b1, '0);

    // Overflow
    for (int i = 1; i <= 8; i++) c8(1'b0, 1'b1, 1'b0, DW'(i));
    c8(1'b0, 1'b1, 1'b0, DW'(9));
    check("ovf_pulse", 32'(ovf8), 32'd1);
`ifdef AVR_CPU_STACK_WRAP_EN
    check("ovf_dout", 32'(dout8), 32'd9);
`else
    check("ovf_dout", 32'(dout8), 32'd8);
`endif
    c8(1'b0, 1'b0, 1'b0, '0);
    check("ovf_one_cycle", 32'(ovf8), 32'd0);
    for (int i = 0; i < 8; i++) begin
`ifdef AVR_CPU_STACK_WRAP_EN
      check("ovf_drain", 32'(dout8), 32'(9 - i));
`else
      check("ovf_drain", 32'(dout8), 32'(8 - i));
`endif
      c8(1'b0, 1'b0, 1'b1, '0);
    end

    // Underflow
    c8(1'b0, 1'b0, 1'b1, '0);
    check("unf_pulse", 32'(unf8), 32'd1);
    check("unf_level", 32'(level8), 32'd0);
    c8(1'b0, 1'b1, 1'b1, DW'(5));
    check("pp_empty_level", 32'(level8), 32'd1);
    check("pp_empty_dout",  32'(dout8),  32'd5);
    check("pp_empty_unf",   32'(unf8),   32'd1);
    c8(1'b0, 1'b0, 1'b1, '0);

    // Reset beats push
    for (int i = 0; i < 3; i++) c8(1'b0, 1'b1, 1'b0, DW'(32'h100 + i));
    c8(1'b1, 1'b1, 1'b0, DW'(32'h1FF));
    c8(1'b0, 1'b0, 1'b0, '0);
    check("rstpush_level", 32'(level8), 32'd0);
    check("rstpush_dout",  32'(dout8),  32'd0);
    check("rstpush_flags", 32'({ovf8, unf8}), 32'd0);

    // Depth-5: push/pop patterns that walk the pointer across the wrap
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, DW'(32'h200 + 2 * i));
      cyc(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, DW'(32'h201 + 2 * i));
      cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, '0);
      if (i % 4 == 3) cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, '0);
    end

    // Random traffic on both instances
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) == 0),
          1'($urandom), 1'($urandom), DW'($urandom),
          1'($urandom), 1'($urandom), DW'($urandom));
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
